// File: rtl/dvi_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dvi_tx_pkg                                                   |
// | Description : Shared types and TMDS control tokens for the DVI TX lane     |
// |               sequencer.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dvi_tx_pkg;

  // Lane sequencer states, in bring-up order.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PHY_RST = 2'd1,
    SETTLE  = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  // TMDS control tokens indexed by {C1,C0}. Token 00 is the blanking token
  // driven whenever the link is not carrying pixel data.
  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  // Timer width able to hold 0..max(a,b)-1; never narrower than one bit.
  function automatic int tmr_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_tx_lock_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dvi_tx_lock_filter                                           |
// | Description : Two-flop synchroniser for the PLL lock flag followed by a    |
// |               saturating run-length counter; lock_ok asserts only after    |
// |               LOCK_FILTER consecutive synchronised lock cycles.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dvi_tx_lock_filter #(
  parameter int LOCK_FILTER = 4
) (
  input  logic pixel_clock,
  input  logic reset,
  input  logic pll_lock,
  output logic lock_ok
);

  localparam int              CNT_W   = $clog2(LOCK_FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER);

  logic [1:0]       sync_q;
  logic [1:0]       sync_d;
  logic             lock_s;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Shift the raw lock flag through the synchroniser; count consecutive lock
  // cycles, saturating at the filter length and clearing on any drop.
  always_comb begin
    sync_d = {sync_q[0], pll_lock};
    lock_s = sync_q[1];
    if (!lock_s) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser and counter registers.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lock_ok = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/dvi_tx_lane_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dvi_tx_lane_sequencer                                        |
// | Description : Bring-up and run-time controller for the three DVI TMDS      |
// |               serializer lanes: filters PLL lock, sequences PHY reset and  |
// |               the settle token, then forwards encoder words to the lanes.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dvi_tx_lane_sequencer
  import dvi_tx_pkg::*;
#(
  parameter int LOCK_FILTER   = 4,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  pixel_clock,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  enable,
  input  logic [9:0]            enc_data_ch0,
  input  logic [9:0]            enc_data_ch1,
  input  logic [9:0]            enc_data_ch2,
  output logic                  phy_reset,
  output logic [9:0]            lane_data_ch0,
  output logic [9:0]            lane_data_ch1,
  output logic [9:0]            lane_data_ch2,
  output logic                  link_up,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int                    TMR_W       = tmr_width(RST_CYCLES, SETTLE_CYCLES);
  localparam logic [TMR_W-1:0]      RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]      SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

  logic                  lock_ok;
  logic                  link_ok;
  seq_state_t            state_q;
  seq_state_t            state_d;
  logic [TMR_W-1:0]      tmr_q;
  logic [TMR_W-1:0]      tmr_d;
  logic                  phy_reset_q;
  logic                  phy_reset_d;
  logic [2:0][9:0]       enc_bus;
  logic [2:0][9:0]       lane_q;
  logic [2:0][9:0]       lane_d;
  logic [LOSS_CNT_W-1:0] loss_q;
  logic [LOSS_CNT_W-1:0] loss_d;

  dvi_tx_lock_filter #(
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .lock_ok     (lock_ok)
  );

  assign enc_bus = {enc_data_ch2, enc_data_ch1, enc_data_ch0};

  // Next-state logic; losing lock or enable aborts to IDLE and wins over
  // any timer expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    link_ok = lock_ok && enable;
    case (state_q)
      IDLE: begin
        if (link_ok) state_d = PHY_RST;
      end
      PHY_RST: begin
        if (!link_ok)               state_d = IDLE;
        else if (tmr_q == RST_LAST) state_d = SETTLE;
      end
      SETTLE: begin
        if (!link_ok)                  state_d = IDLE;
        else if (tmr_q == SETTLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (!link_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer, lane mux, PHY reset and loss counter, all decoded from the next
  // state so the registered outputs line up with the state they belong to.
  always_comb begin
    tmr_d       = '0;
    phy_reset_d = (state_d == IDLE) || (state_d == PHY_RST);
    lane_d      = {CTRL_TOKEN_00, CTRL_TOKEN_00, CTRL_TOKEN_00};
    loss_d      = loss_q;

    if ((state_d == state_q) && ((state_q == PHY_RST) || (state_q == SETTLE))) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    if (state_d == RUN) begin
      lane_d = enc_bus;
    end

    // Only a lock-loss exit from RUN counts; an enable-only exit does not.
    if ((state_q == RUN) && (state_d == IDLE) && !lock_ok && (loss_q != LOSS_MAX)) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  // State and output registers; reset forces the safe idle outputs at once.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      phy_reset_q <= 1'b1;
      lane_q      <= {CTRL_TOKEN_00, CTRL_TOKEN_00, CTRL_TOKEN_00};
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      phy_reset_q <= phy_reset_d;
      lane_q      <= lane_d;
      loss_q      <= loss_d;
    end
  end

  assign phy_reset       = phy_reset_q;
  assign lane_data_ch0   = lane_q[0];
  assign lane_data_ch1   = lane_q[1];
  assign lane_data_ch2   = lane_q[2];
  assign link_up         = (state_q == RUN);
  assign lock_loss_count = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_dvi_tx_lane_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dvi_tx_lane_sequencer                                     |
// | Description : Self-checking bench for dvi_tx_lane_sequencer: vector table, |
// |               hand-written corner sequences and randomised stimulus        |
// |               against a bring-up progress model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dvi_tx_lane_sequencer;
  import dvi_tx_pkg::*;

  localparam int LF      = 4;
  localparam int RC      = 8;
  localparam int SC      = 16;
  localparam int LW      = 8;
  localparam int RUN_AT  = RC + SC;  // model progress value meaning "running"
  localparam int LOSS_SAT = (1 << LW) - 1;

  logic          pixel_clock = 1'b0;
  logic          reset;
  logic          pll_lock;
  logic          enable;
  logic [9:0]    enc0, enc1, enc2;
  logic          phy_reset;
  logic [9:0]    lane0, lane1, lane2;
  logic          link_up;
  logic [LW-1:0] loss;

  dvi_tx_lane_sequencer #(
    .LOCK_FILTER   (LF),
    .RST_CYCLES    (RC),
    .SETTLE_CYCLES (SC),
    .LOSS_CNT_W    (LW)
  ) dut (
    .pixel_clock     (pixel_clock),
    .reset           (reset),
    .pll_lock        (pll_lock),
    .enable          (enable),
    .enc_data_ch0    (enc0),
    .enc_data_ch1    (enc1),
    .enc_data_ch2    (enc2),
    .phy_reset       (phy_reset),
    .lane_data_ch0   (lane0),
    .lane_data_ch1   (lane1),
    .lane_data_ch2   (lane2),
    .link_up         (link_up),
    .lock_loss_count (loss)
  );

  always #5 pixel_clock = ~pixel_clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bring-up progress -1 = idle, 0..RC-1 = PHY in reset,
  // RC..RUN_AT-1 = settle token, RUN_AT = running. Lock is a run length of
  // synchronised lock samples.
  int         m_prog;
  int         m_run;
  int         m_loss;
  bit         m_s1, m_s2;
  logic [9:0] m_l0, m_l1, m_l2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prog = -1;
    m_run  = 0;
    m_loss = 0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_l0   = CTRL_TOKEN_00;
    m_l1   = CTRL_TOKEN_00;
    m_l2   = CTRL_TOKEN_00;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit ok;
    ok = (m_run >= LF);
    if (m_prog < 0) begin
      if (ok && enable) m_prog = 0;
    end else if (!(ok && enable)) begin
      if (m_prog >= RUN_AT && !ok) m_loss = (m_loss < LOSS_SAT) ? m_loss + 1 : LOSS_SAT;
      m_prog = -1;
    end else if (m_prog < RUN_AT) begin
      m_prog = m_prog + 1;
    end
    if (m_prog >= RUN_AT) begin
      m_l0 = enc0; m_l1 = enc1; m_l2 = enc2;
    end else begin
      m_l0 = CTRL_TOKEN_00; m_l1 = CTRL_TOKEN_00; m_l2 = CTRL_TOKEN_00;
    end
    m_run = m_s2 ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    m_s2  = m_s1;
    m_s1  = pll_lock;
  endtask

  // One clock edge, then compare every output with the model.
  task automatic step();
    model_edge();
    @(posedge pixel_clock);
    #1;
    chk("m_link_up",   32'(link_up),   32'(m_prog >= RUN_AT));
    chk("m_phy_reset", 32'(phy_reset), 32'(m_prog < RC));
    chk("m_lanes",     32'({lane0, lane1, lane2}), 32'({m_l0, m_l1, m_l2}));
    chk("m_loss",      32'(loss),      32'(m_loss));
  endtask

  task automatic rand_enc();
    enc0 = 10'($urandom_range(1023));
    enc1 = 10'($urandom_range(1023));
    enc2 = 10'($urandom_range(1023));
  endtask

  task automatic wait_link(input logic val, input int bound, input string name, output int edges);
    edges = 0;
    while (link_up !== val && edges < bound) begin
      rand_enc();
      step();
      edges++;
    end
    chk(name, 32'(link_up), 32'(val));
  endtask

  task automatic wait_phy_low(input int bound, input string name, output int edges);
    edges = 0;
    while (phy_reset !== 1'b0 && edges < bound) begin
      step();
      edges++;
    end
    chk(name, 32'(phy_reset), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_phy_reset"}, 32'(phy_reset), 32'd1);
    chk({tag, "_link_up"},   32'(link_up),   32'd0);
    chk({tag, "_lanes"},     32'({lane0, lane1, lane2}),
        32'({CTRL_TOKEN_00, CTRL_TOKEN_00, CTRL_TOKEN_00}));
    chk({tag, "_loss"},      32'(loss),      32'd0);
  endtask

  typedef struct {
    logic       en;
    logic [9:0] e0, e1, e2;
    logic       x_link;
    logic       x_rst;
    logic [9:0] x0, x1, x2;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int first_up, first_low, edges, saved;

    // In RUN, words appear one edge after they are applied, all lanes
    // together; the last row drops enable and must fall straight to idle.
    tbl[0] = '{1'b1, 10'h001, 10'h101, 10'h201, 1'b1, 1'b0, 10'h001, 10'h101, 10'h201};
    tbl[1] = '{1'b1, 10'h002, 10'h102, 10'h202, 1'b1, 1'b0, 10'h002, 10'h102, 10'h202};
    tbl[2] = '{1'b1, 10'h003, 10'h103, 10'h203, 1'b1, 1'b0, 10'h003, 10'h103, 10'h203};
    tbl[3] = '{1'b1, 10'h3FF, 10'h000, 10'h2AA, 1'b1, 1'b0, 10'h3FF, 10'h000, 10'h2AA};
    tbl[4] = '{1'b0, 10'h155, 10'h0F0, 10'h30F, 1'b0, 1'b1, 10'h354, 10'h354, 10'h354};

    // Reset values, with no clock edge yet.
    reset = 1'b1; pll_lock = 1'b1; enable = 1'b1;
    enc0 = '0; enc1 = '0; enc2 = '0;
    model_reset();
    #2;
    chk_reset_outputs("por");
    repeat (2) @(posedge pixel_clock);
    #1 reset = 1'b0;

    // Bring-up with lock held: two synchroniser edges, then 4+1+8+16.
    first_up = -1; first_low = -1;
    for (int e = 1; e <= 40; e++) begin
      rand_enc();
      step();
      if (first_up < 0 && link_up === 1'b1) first_up = e;
      if (first_low < 0 && phy_reset === 1'b0) first_low = e;
      if (e == 30) chk("token_before_run", 32'(lane1), 32'(CTRL_TOKEN_00));
    end
    chk("bringup_link_edge", 32'(first_up), 32'd31);
    chk("bringup_phy_fall",  32'(first_low), 32'd15);

    // Data path in RUN from the vector table.
    for (int i = 0; i < 5; i++) begin
      enable = tbl[i].en;
      enc0 = tbl[i].e0; enc1 = tbl[i].e1; enc2 = tbl[i].e2;
      step();
      chk($sformatf("tbl%0d_link", i),  32'(link_up),   32'(tbl[i].x_link));
      chk($sformatf("tbl%0d_rst", i),   32'(phy_reset), 32'(tbl[i].x_rst));
      chk($sformatf("tbl%0d_lanes", i), 32'({lane0, lane1, lane2}),
          32'({tbl[i].x0, tbl[i].x1, tbl[i].x2}));
    end

    // Enable drop in SETTLE at tmr=5: back to idle, no loss counted; lock
    // is still good so re-enabling enters PHY reset on the very next edge.
    saved = int'(loss);
    enable = 1'b1;
    wait_phy_low(20, "reenable_phy_low", edges);
    chk("reenable_phy_edges", 32'(edges), 32'd9);
    repeat (5) step();
    enable = 1'b0;
    step();
    chk("settle_abort_rst",  32'(phy_reset), 32'd1);
    chk("settle_abort_loss", 32'(loss), 32'(saved));
    enable = 1'b1;
    wait_phy_low(20, "settle_reen_phy_low", edges);
    chk("settle_reen_edges", 32'(edges), 32'd9);
    wait_link(1'b1, 40, "settle_reen_link", edges);

    // One-cycle lock drop in RUN: counted loss, then full relock.
    saved = int'(loss);
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    wait_link(1'b0, 10, "drop_link_fall", edges);
    chk("drop_loss_inc", 32'(loss), 32'(saved + 1));
    chk("drop_phy_rst",  32'(phy_reset), 32'd1);
    chk("drop_lanes",    32'({lane0, lane1, lane2}),
        32'({CTRL_TOKEN_00, CTRL_TOKEN_00, CTRL_TOKEN_00}));
    // Drop edge + link-fall edges + relock edges = 32 edges from the drop.
    wait_link(1'b1, 60, "relock_link", first_up);
    chk("relock_edges", 32'(1 + edges + first_up), 32'd32);

    // Lock flicker with runs of three: the filter never qualifies.
    pll_lock = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 48; i++) begin
      pll_lock = (i % 4) != 3;
      step();
      if (phy_reset !== 1'b1 || link_up !== 1'b0)
        chk($sformatf("flicker_%0d", i), 32'({phy_reset, link_up}), 32'b10);
    end
    chk("flicker_end_rst", 32'(phy_reset), 32'd1);

    // Randomised lock/enable/data against the model.
    for (int i = 0; i < 4000; i++) begin
      pll_lock = ($urandom_range(99) < 97);
      enable   = ($urandom_range(99) < 98);
      rand_enc();
      step();
    end

    // 300 lock-loss events from RUN: counter saturates.
    pll_lock = 1'b1; enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_link(1'b1, 80, "sat_link_up", edges);
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
      wait_link(1'b0, 10, "sat_link_down", edges);
    end
    chk("loss_saturated", 32'(loss), 32'(LOSS_SAT));

    // Async reset in the middle of PHY reset: outputs clear before any edge.
    edges = 0;
    while (!(m_prog >= 0 && m_prog < RC) && edges < 40) begin
      step();
      edges++;
    end
    chk("reach_phy_rst", 32'(m_prog >= 0 && m_prog < RC), 32'd1);
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("async_phy_rst");
    model_reset();
    @(posedge pixel_clock);
    #1 reset = 1'b0;

    // After reset the full bring-up repeats, then reset once more in RUN.
    wait_link(1'b1, 40, "post_reset_link", edges);
    chk("post_reset_edges", 32'(edges), 32'd31);
    rand_enc();
    step();
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("async_run");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
